// File: rtl/axi_rd_router_pkg.sv
// Shared constants, default-slave state type and sizing helper for axi_rd_router.
package axi_rd_router_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dflt_state_e;

    // Width of a target index covering NUM_SLAVES mapped slaves plus the default slave.
    function automatic int unsigned tgt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axi_default_slave_r.sv
// DECERR responder: accepts one AR at a time and returns ARLEN+1 zero-data DECERR beats.
module axi_default_slave_r
    import axi_rd_router_pkg::*;
#(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [3:0]        arlen,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast
);

    localparam int unsigned LEN_W = 4;

    dflt_state_e      state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] beat_q, beat_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             arready_q, arready_d;
    logic             rvalid_q, rvalid_d;
    logic             rlast_q, rlast_d;

    // Next state, burst bookkeeping and the registered handshake outputs.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (arvalid && arready_q) begin
                    id_d    = arid;
                    len_d   = arlen;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        arready_d = (state_d == IDLE);
        rvalid_d  = (state_d == BUSY);
        rlast_d   = (state_d == BUSY) && (beat_d == len_d);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            beat_q    <= '0;
            id_q      <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            id_q      <= id_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = id_q;
    assign rdata   = '0;
    assign rresp   = RESP_DECERR;

endmodule

// File: rtl/axi_rd_router.sv
// AXI read router: address-decoded AR steering, in-order R return via a target tracking FIFO.
// Optional unmapped-address capture log enabled by defining ADDR_ERR_LOG_EN.
module axi_rd_router
    import axi_rd_router_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 6,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ID_W       = 8,
    parameter int unsigned MAX_OUTST  = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {
        32'h0005_0000, 32'h0004_0000, 32'h0003_0000,
        32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LAST = {
        32'h0005_FFFF, 32'h0004_FFFF, 32'h0003_FFFF,
        32'h0002_FFFF, 32'h0001_FFFF, 32'h0000_FFFF}
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ID_W-1:0]              ARID_M,
    input  logic [ADDR_W-1:0]            ARADDR_M,
    input  logic [3:0]                   ARLEN_M,
    input  logic                         ARVALID_M,
    output logic                         ARREADY_M,
    output logic [NUM_SLAVES-1:0]        ARVALID_S,
    input  logic [NUM_SLAVES-1:0]        ARREADY_S,
    input  logic [NUM_SLAVES*ID_W-1:0]   RID_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] RDATA_S,
    input  logic [NUM_SLAVES*2-1:0]      RRESP_S,
    input  logic [NUM_SLAVES-1:0]        RLAST_S,
    input  logic [NUM_SLAVES-1:0]        RVALID_S,
    output logic [NUM_SLAVES-1:0]        RREADY_S,
`ifdef ADDR_ERR_LOG_EN
    input  logic                         ERR_CLR,
    output logic                         ERR_VALID,
    output logic [ADDR_W-1:0]            ERR_ADDR,
`endif
    output logic [ID_W-1:0]              RID_M,
    output logic [DATA_W-1:0]            RDATA_M,
    output logic [1:0]                   RRESP_M,
    output logic                         RLAST_M,
    output logic                         RVALID_M,
    input  logic                         RREADY_M
);

    localparam int unsigned TGT_W = tgt_w(NUM_SLAVES);
    localparam int unsigned PTR_W = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [TGT_W-1:0] DFLT_TGT = TGT_W'(NUM_SLAVES);

    logic [TGT_W-1:0]  tgt_c;
    logic              tgt_found_c;
    logic              full_c, empty_c, ar_en_c, ar_hs_c, pop_c;
    logic [NUM_SLAVES:0] arready_all_c;
    logic [TGT_W-1:0]  head_c;

    logic              dflt_arvalid_c, dflt_arready, dflt_rvalid, dflt_rready_c, dflt_rlast;
    logic [ID_W-1:0]   dflt_rid;
    logic [DATA_W-1:0] dflt_rdata;
    logic [1:0]        dflt_rresp;

    logic [TGT_W-1:0]  fifo_q [MAX_OUTST];
    logic [TGT_W-1:0]  fifo_d [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Address decode: inclusive ranges, lowest matching index wins, no match selects the default slave.
    always_comb begin
        tgt_c       = DFLT_TGT;
        tgt_found_c = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!tgt_found_c &&
                (ARADDR_M >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
                (ARADDR_M <= SLV_LAST[i*ADDR_W +: ADDR_W])) begin
                tgt_c       = TGT_W'(i);
                tgt_found_c = 1'b1;
            end
        end
    end

    assign full_c        = (cnt_q == CNT_W'(MAX_OUTST));
    assign empty_c       = (cnt_q == '0);
    assign arready_all_c = {dflt_arready, ARREADY_S};
    assign ar_en_c       = ARESETn & ARVALID_M & ~full_c;
    assign ARREADY_M     = ARESETn & ~full_c & arready_all_c[tgt_c];
    assign ar_hs_c       = ARVALID_M & ARREADY_M;
    assign dflt_arvalid_c = ar_en_c & (tgt_c == DFLT_TGT);
    assign head_c        = fifo_q[rd_ptr_q];

    // AR valid steering to the decoded mapped slave.
    always_comb begin
        ARVALID_S = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            ARVALID_S[i] = ar_en_c & (tgt_c == TGT_W'(i));
        end
    end

    // R return mux driven by the oldest outstanding target.
    always_comb begin
        RVALID_M      = 1'b0;
        RID_M         = '0;
        RDATA_M       = '0;
        RRESP_M       = RESP_OKAY;
        RLAST_M       = 1'b0;
        RREADY_S      = '0;
        dflt_rready_c = 1'b0;
        if (ARESETn && !empty_c) begin
            if (head_c == DFLT_TGT) begin
                RVALID_M      = dflt_rvalid;
                RID_M         = dflt_rid;
                RDATA_M       = dflt_rdata;
                RRESP_M       = dflt_rresp;
                RLAST_M       = dflt_rlast;
                dflt_rready_c = RREADY_M;
            end
            for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
                if (head_c == TGT_W'(i)) begin
                    RVALID_M    = RVALID_S[i];
                    RID_M       = RID_S[i*ID_W +: ID_W];
                    RDATA_M     = RDATA_S[i*DATA_W +: DATA_W];
                    RRESP_M     = RRESP_S[i*2 +: 2];
                    RLAST_M     = RLAST_S[i];
                    RREADY_S[i] = RREADY_M;
                end
            end
        end
    end

    assign pop_c = RVALID_M & RREADY_M & RLAST_M;

    // Tracking FIFO next state: push on AR handshake, pop on last R beat.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (ar_hs_c) begin
            fifo_d[wr_ptr_q] = tgt_c;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({ar_hs_c, pop_c})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Tracking FIFO registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int unsigned i = 0; i < MAX_OUTST; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    axi_default_slave_r #(
        .ID_W   (ID_W),
        .DATA_W (DATA_W)
    ) u_dflt (
        .clk     (ACLK),
        .rst_n   (ARESETn),
        .arvalid (dflt_arvalid_c),
        .arready (dflt_arready),
        .arid    (ARID_M),
        .arlen   (ARLEN_M),
        .rvalid  (dflt_rvalid),
        .rready  (dflt_rready_c),
        .rid     (dflt_rid),
        .rdata   (dflt_rdata),
        .rresp   (dflt_rresp),
        .rlast   (dflt_rlast)
    );

`ifdef ADDR_ERR_LOG_EN
    logic              err_valid_q, err_valid_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // Sticky capture of the first unmapped address; a coinciding capture beats the clear.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        if (ar_hs_c && (tgt_c == DFLT_TGT) && (!err_valid_q || ERR_CLR)) begin
            err_valid_d = 1'b1;
            err_addr_d  = ARADDR_M;
        end else if (ERR_CLR) begin
            err_valid_d = 1'b0;
            err_addr_d  = '0;
        end
    end

    // Error log registers.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign ERR_VALID = err_valid_q;
    assign ERR_ADDR  = err_addr_q;
`endif

endmodule

// File: tb/tb_axi_rd_router.sv
// Directed self-checking bench for axi_rd_router (covers ADDR_ERR_LOG_EN when defined).
module tb_axi_rd_router;

    localparam int unsigned NS = 6;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 8;

    // S2/S3 overlap on 0x0010_8000..0x0010_FFFF.
    localparam logic [NS*AW-1:0] BASE = {32'h0300_0000, 32'h0200_0000, 32'h0010_8000,
                                         32'h0010_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] LAST = {32'h0300_FFFF, 32'h0200_FFFF, 32'h0011_FFFF,
                                         32'h0010_FFFF, 32'h0001_FFFF, 32'h0000_FFFF};

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic [IW-1:0]   ARID_M;
    logic [AW-1:0]   ARADDR_M;
    logic [3:0]      ARLEN_M;
    logic            ARVALID_M;
    logic            ARREADY_M;
    logic [NS-1:0]   ARVALID_S;
    logic [NS-1:0]   ARREADY_S;
    logic [NS*IW-1:0] RID_S;
    logic [NS*DW-1:0] RDATA_S;
    logic [NS*2-1:0] RRESP_S;
    logic [NS-1:0]   RLAST_S;
    logic [NS-1:0]   RVALID_S;
    logic [NS-1:0]   RREADY_S;
    logic [IW-1:0]   RID_M;
    logic [DW-1:0]   RDATA_M;
    logic [1:0]      RRESP_M;
    logic            RLAST_M;
    logic            RVALID_M;
    logic            RREADY_M;
`ifdef ADDR_ERR_LOG_EN
    logic            ERR_CLR;
    logic            ERR_VALID;
    logic [AW-1:0]   ERR_ADDR;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] ar_addr [4];
    logic [IW-1:0] ar_id   [4];
    logic [3:0]    ar_len  [4];
    logic [AW-1:0] bnd_addr   [7];
    logic [NS-1:0] bnd_avalid [7];
    logic          bnd_aready [7];

    always #5 ACLK = ~ACLK;

    axi_rd_router #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .ID_W       (IW),
        .MAX_OUTST  (4),
        .SLV_BASE   (BASE),
        .SLV_LAST   (LAST)
    ) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .ARID_M    (ARID_M),
        .ARADDR_M  (ARADDR_M),
        .ARLEN_M   (ARLEN_M),
        .ARVALID_M (ARVALID_M),
        .ARREADY_M (ARREADY_M),
        .ARVALID_S (ARVALID_S),
        .ARREADY_S (ARREADY_S),
        .RID_S     (RID_S),
        .RDATA_S   (RDATA_S),
        .RRESP_S   (RRESP_S),
        .RLAST_S   (RLAST_S),
        .RVALID_S  (RVALID_S),
        .RREADY_S  (RREADY_S),
`ifdef ADDR_ERR_LOG_EN
        .ERR_CLR   (ERR_CLR),
        .ERR_VALID (ERR_VALID),
        .ERR_ADDR  (ERR_ADDR),
`endif
        .RID_M     (RID_M),
        .RDATA_M   (RDATA_M),
        .RRESP_M   (RRESP_M),
        .RLAST_M   (RLAST_M),
        .RVALID_M  (RVALID_M),
        .RREADY_M  (RREADY_M)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_r(input int s, input logic [IW-1:0] id, input logic [DW-1:0] data,
                         input logic last, input logic v);
        RID_S[s*IW +: IW]   = id;
        RDATA_S[s*DW +: DW] = data;
        RRESP_S[s*2 +: 2]   = 2'b00;
        RLAST_S[s]          = last;
        RVALID_S[s]         = v;
    endtask

    task automatic set_ar(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                          input logic [3:0] len, input logic v);
        ARADDR_M  = addr;
        ARID_M    = id;
        ARLEN_M   = len;
        ARVALID_M = v;
    endtask

    initial begin
        ar_addr[0] = 32'h0000_0100; ar_id[0] = 8'h01; ar_len[0] = 4'd1;
        ar_addr[1] = 32'h0001_0200; ar_id[1] = 8'h02; ar_len[1] = 4'd0;
        ar_addr[2] = 32'h0000_0300; ar_id[2] = 8'h03; ar_len[2] = 4'd0;
        ar_addr[3] = 32'h0001_0400; ar_id[3] = 8'h04; ar_len[3] = 4'd0;

        bnd_addr[0] = 32'h0000_FFFF; bnd_avalid[0] = 6'b000001; bnd_aready[0] = 1'b0;
        bnd_addr[1] = 32'h0001_0000; bnd_avalid[1] = 6'b000010; bnd_aready[1] = 1'b0;
        bnd_addr[2] = 32'h0000_0000; bnd_avalid[2] = 6'b000001; bnd_aready[2] = 1'b0;
        bnd_addr[3] = 32'h0010_8000; bnd_avalid[3] = 6'b000100; bnd_aready[3] = 1'b0;
        bnd_addr[4] = 32'h0011_0000; bnd_avalid[4] = 6'b001000; bnd_aready[4] = 1'b0;
        bnd_addr[5] = 32'h0200_0000; bnd_avalid[5] = 6'b010000; bnd_aready[5] = 1'b0;
        bnd_addr[6] = 32'hFFFF_FFFF; bnd_avalid[6] = 6'b000000; bnd_aready[6] = 1'b1;

        // Reset with busy-looking inputs: every output must be quiet.
        ARESETn   = 1'b0;
        set_ar(32'h0000_0010, 8'h00, 4'd0, 1'b1);
        ARREADY_S = '1;
        RVALID_S  = '1;
        RLAST_S   = '1;
        RID_S     = '1;
        RDATA_S   = '1;
        RRESP_S   = '1;
        RREADY_M  = 1'b1;
`ifdef ADDR_ERR_LOG_EN
        ERR_CLR   = 1'b0;
`endif
        repeat (2) @(negedge ACLK);
        chk("rst_arready_m", 64'(ARREADY_M), 64'd0);
        chk("rst_arvalid_s", 64'(ARVALID_S), 64'd0);
        chk("rst_rvalid_m",  64'(RVALID_M),  64'd0);
        chk("rst_rready_s",  64'(RREADY_S),  64'd0);
        chk("rst_rlast_m",   64'(RLAST_M),   64'd0);
        chk("rst_rid_m",     64'(RID_M),     64'd0);
        chk("rst_rdata_m",   64'(RDATA_M),   64'd0);
`ifdef ADDR_ERR_LOG_EN
        chk("rst_err_valid", 64'(ERR_VALID), 64'd0);
        chk("rst_err_addr",  64'(ERR_ADDR),  64'd0);
`endif
        ARESETn   = 1'b1;
        ARVALID_M = 1'b0;
        RVALID_S  = '0;
        RLAST_S   = '0;
        RRESP_S   = '0;
        RREADY_M  = 1'b0;
        @(negedge ACLK);

        // 4-beat burst to S1.
        set_ar(32'h0001_0004, 8'h11, 4'd3, 1'b1);
        #1;
        chk("s1_arvalid_s", 64'(ARVALID_S), 64'b000010);
        chk("s1_arready_m", 64'(ARREADY_M), 64'd1);
        @(negedge ACLK);
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_r(1, 8'h11, 32'hA000_0000 + 32'(k), (k == 3), 1'b1);
            #1;
            chk("s1_rvalid", 64'(RVALID_M), 64'd1);
            chk("s1_rid",    64'(RID_M),    64'h11);
            chk("s1_rdata",  64'(RDATA_M),  64'hA000_0000 + 64'(k));
            chk("s1_rlast",  64'(RLAST_M),  64'(k == 3));
            chk("s1_rready_s", 64'(RREADY_S), 64'b000010);
            @(negedge ACLK);
        end
        #1;
        chk("s1_empty_rvalid", 64'(RVALID_M), 64'd0);
        chk("s1_empty_rready", 64'(RREADY_S), 64'd0);
        set_r(1, 8'h00, 32'h0, 1'b0, 1'b0);

        // Unmapped AR -> 3 DECERR beats from the default slave.
        @(negedge ACLK);
        set_ar(32'h8000_0000, 8'h21, 4'd2, 1'b1);
        #1;
        chk("dec_arready_m", 64'(ARREADY_M), 64'd1);
        chk("dec_arvalid_s", 64'(ARVALID_S), 64'd0);
        @(negedge ACLK);
        ARVALID_M = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("dec_rvalid", 64'(RVALID_M), 64'd1);
            chk("dec_rresp",  64'(RRESP_M),  64'd3);
            chk("dec_rdata",  64'(RDATA_M),  64'd0);
            chk("dec_rid",    64'(RID_M),    64'h21);
            chk("dec_rlast",  64'(RLAST_M),  64'(k == 2));
            @(negedge ACLK);
        end
        #1;
        chk("dec_done_rvalid", 64'(RVALID_M), 64'd0);
`ifdef ADDR_ERR_LOG_EN
        chk("err_valid_set", 64'(ERR_VALID), 64'd1);
        chk("err_addr_cap",  64'(ERR_ADDR),  64'h8000_0000);
        @(negedge ACLK);
        set_ar(32'h7000_0000, 8'h22, 4'd0, 1'b1);
        @(negedge ACLK);
        ARVALID_M = 1'b0;
        #1;
        chk("err2_rlast", 64'(RLAST_M), 64'd1);
        @(negedge ACLK);
        chk("err_addr_sticky", 64'(ERR_ADDR), 64'h8000_0000);
        ERR_CLR = 1'b1;
        @(negedge ACLK);
        ERR_CLR = 1'b0;
        #1;
        chk("err_valid_clr", 64'(ERR_VALID), 64'd0);
`endif

        // Fill the tracking FIFO with R withheld, then drain in order.
        @(negedge ACLK);
        RREADY_M = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_ar(ar_addr[i], ar_id[i], ar_len[i], 1'b1);
            #1;
            chk("fill_arready", 64'(ARREADY_M), 64'd1);
            @(negedge ACLK);
        end
        set_ar(32'h0000_0500, 8'h05, 4'd0, 1'b1);
        #1;
        chk("full_arready", 64'(ARREADY_M), 64'd0);
        chk("full_arvalid_s", 64'(ARVALID_S), 64'd0);
        set_r(1, 8'h02, 32'hB100_0002, 1'b1, 1'b1);
        RREADY_M = 1'b1;
        #1;
        chk("early_s1_rvalid_m", 64'(RVALID_M), 64'd0);
        chk("early_s1_rready_s", 64'(RREADY_S), 64'b000001);
        @(negedge ACLK);
        set_r(0, 8'h01, 32'hB000_0000, 1'b0, 1'b1);
        #1;
        chk("s0b0_rdata",   64'(RDATA_M),   64'hB000_0000);
        chk("s0b0_rready_s", 64'(RREADY_S), 64'b000001);
        chk("s0b0_arready", 64'(ARREADY_M), 64'd0);
        @(negedge ACLK);
        set_r(0, 8'h01, 32'hB000_0001, 1'b1, 1'b1);
        #1;
        chk("s0b1_rlast",   64'(RLAST_M),   64'd1);
        chk("pop_full_arready", 64'(ARREADY_M), 64'd0);
        @(negedge ACLK);
        set_r(0, 8'h00, 32'h0, 1'b0, 1'b0);
        #1;
        chk("pushpop_arready", 64'(ARREADY_M), 64'd1);
        chk("s1_head_rid",     64'(RID_M),     64'h02);
        chk("s1_head_rready",  64'(RREADY_S),  64'b000010);
        @(negedge ACLK);
        ARVALID_M = 1'b0;
        set_r(1, 8'h00, 32'h0, 1'b0, 1'b0);
        set_r(0, 8'h03, 32'hB000_0003, 1'b1, 1'b1);
        #1;
        chk("head3_rid",    64'(RID_M),    64'h03);
        chk("head3_rready", 64'(RREADY_S), 64'b000001);
        @(negedge ACLK);
        set_r(0, 8'h00, 32'h0, 1'b0, 1'b0);
        set_r(1, 8'h04, 32'hB100_0004, 1'b1, 1'b1);
        #1;
        chk("head4_rid", 64'(RID_M), 64'h04);
        @(negedge ACLK);
        set_r(1, 8'h00, 32'h0, 1'b0, 1'b0);
        set_r(0, 8'h05, 32'hB000_0005, 1'b1, 1'b1);
        #1;
        chk("head5_rid",   64'(RID_M),   64'h05);
        chk("head5_rdata", 64'(RDATA_M), 64'hB000_0005);
        @(negedge ACLK);
        #1;
        chk("drained_rvalid", 64'(RVALID_M), 64'd0);
        set_r(0, 8'h00, 32'h0, 1'b0, 1'b0);
        RREADY_M = 1'b0;

        // Decode boundaries and overlap priority, with slave ARREADY held low.
        ARREADY_S = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge ACLK);
            set_ar(bnd_addr[i], 8'h00, 4'd0, 1'b1);
            #1;
            chk("bnd_arvalid_s", 64'(ARVALID_S), 64'(bnd_avalid[i]));
            chk("bnd_arready_m", 64'(ARREADY_M), 64'(bnd_aready[i]));
            ARVALID_M = 1'b0;
        end
        ARREADY_S = '1;

        // Reset during beat 2 of a DECERR burst.
        @(negedge ACLK);
        RREADY_M = 1'b1;
        set_ar(32'h9000_0000, 8'h33, 4'd3, 1'b1);
        @(negedge ACLK);
        ARVALID_M = 1'b0;
        #1;
        chk("mid_b1_rlast", 64'(RLAST_M), 64'd0);
        @(negedge ACLK);
        #1;
        chk("mid_b2_rvalid", 64'(RVALID_M), 64'd1);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_rvalid",  64'(RVALID_M),  64'd0);
        chk("mid_rst_arready", 64'(ARREADY_M), 64'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        chk("post_rst_rvalid", 64'(RVALID_M), 64'd0);
        set_ar(32'hA000_0000, 8'h44, 4'd0, 1'b1);
        #1;
        chk("post_rst_arready", 64'(ARREADY_M), 64'd1);
`ifdef ADDR_ERR_LOG_EN
        chk("post_rst_err_valid", 64'(ERR_VALID), 64'd0);
`endif
        @(negedge ACLK);
        ARVALID_M = 1'b0;
        #1;
        chk("post_rst_rvalid_new", 64'(RVALID_M), 64'd1);
        chk("post_rst_rid",        64'(RID_M),    64'h44);
        chk("post_rst_rlast",      64'(RLAST_M),  64'd1);
        chk("post_rst_rresp",      64'(RRESP_M),  64'd3);
        @(negedge ACLK);
        #1;
        chk("post_rst_done", 64'(RVALID_M), 64'd0);
`ifdef ADDR_ERR_LOG_EN
        chk("post_rst_err_addr", 64'(ERR_ADDR), 64'hA000_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
